// File: rtl/sysid_uptime.sv
// sysid_uptime: Avalon-MM system-ID slave with a tear-free 64-bit uptime counter.
// Ports: clock/reset, address[2:0], read, write, writedata[31:0] -> readdata[31:0], readdatavalid.
module sysid_uptime #(
  parameter logic [31:0] SYS_ID    = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP = 32'h0000_0000,
  parameter int          NUM_CPUS  = 2,
  parameter int          TICK_DIV  = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  localparam logic [31:0] CONFIG =
    {16'(TICK_DIV), 8'd0, 8'(NUM_CPUS)};
  localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

  logic [63:0] uptime;
  logic [15:0] presc;
  logic [31:0] hi_shadow;
  logic [31:0] scratch0;
  logic [31:0] scratch1;
  logic        freeze;

  logic        ctrl_wr;
  logic        clear;
  logic        tick;
  logic [31:0] rd_mux;

  assign ctrl_wr = write && (address == 3'd7);
  assign clear   = ctrl_wr && writedata[1];
  assign tick    = (presc == PRESC_MAX);

  // CLEAR beats a simultaneous tick and ignores FREEZE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      uptime <= '0;
      presc  <= '0;
    end else if (clear) begin
      uptime <= '0;
      presc  <= '0;
    end else if (!freeze) begin
      if (tick) begin
        presc  <= '0;
        uptime <= uptime + 64'd1;
      end else begin
        presc <= presc + 16'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scratch0 <= '0;
      scratch1 <= '0;
      freeze   <= 1'b0;
    end else if (write) begin
      unique case (address)
        3'd4:    scratch0 <= writedata;
        3'd5:    scratch1 <= writedata;
        3'd7:    freeze   <= writedata[0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (address)
      3'd0: rd_mux = SYS_ID;
      3'd1: rd_mux = TIMESTAMP;
      3'd2: rd_mux = uptime[31:0];
      3'd3: rd_mux = hi_shadow;
      3'd4: rd_mux = scratch0;
      3'd5: rd_mux = scratch1;
      3'd6: rd_mux = CONFIG;
      3'd7: rd_mux = {31'd0, freeze};
      default: rd_mux = '0;
    endcase
  end

  // The UP_LO read latches both halves from the same pre-edge
  // uptime value, so a later UP_HI read can never see a split carry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
      hi_shadow     <= '0;
    end else begin
      readdatavalid <= read;
      if (read) begin
        readdata <= rd_mux;
        if (address == 3'd2)
          hi_shadow <= uptime[63:32];
      end
    end
  end

endmodule

// File: tb/tb_sysid_uptime.sv
// tb_sysid_uptime: randomized bench for sysid_uptime against a cycle-count model.
// Uptime is modelled as (enabled clocks since clear) / TICK_DIV.
module tb_sysid_uptime;

  localparam logic [31:0] SID = 32'h63BB_00C3;
  localparam logic [31:0] TS  = 32'h5F00_0000;
  localparam int          NC  = 4;
  localparam int          TD  = 3;

  logic        clock;
  logic        reset;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        readdatavalid;

  logic [2:0]  address1;
  logic        read1;
  logic        write1;
  logic [31:0] writedata1;
  logic [31:0] readdata1;
  logic        readdatavalid1;

  sysid_uptime #(
    .SYS_ID(SID), .TIMESTAMP(TS),
    .NUM_CPUS(NC), .TICK_DIV(TD)
  ) dut (
    .clock(clock), .reset(reset),
    .address(address), .read(read),
    .write(write), .writedata(writedata),
    .readdata(readdata),
    .readdatavalid(readdatavalid)
  );

  sysid_uptime #(
    .SYS_ID(SID), .TIMESTAMP(TS),
    .NUM_CPUS(1), .TICK_DIV(1)
  ) dut1 (
    .clock(clock), .reset(reset),
    .address(address1), .read(read1),
    .write(write1), .writedata(writedata1),
    .readdata(readdata1),
    .readdatavalid(readdatavalid1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  longint unsigned m_cnt;
  logic [31:0] m_hi, m_s0, m_s1, m_last;
  logic        m_frz;
  bit          use_model;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_hi = '0; m_s0 = '0;
    m_s1 = '0; m_last = '0; m_frz = 1'b0;
  endtask

  // One bus cycle: drive at negedge, model the edge, sample at +1.
  task automatic cyc(input logic rd, input logic wr,
                     input logic [2:0] a, input logic [31:0] d);
    logic [63:0] up;
    logic [31:0] exp;
    logic        frz_old;
    string       t;
    read = rd; write = wr; address = a; writedata = d;
    up  = m_cnt / longint'(TD);
    exp = m_last;
    if (rd) begin
      case (a)
        3'd0: exp = SID;
        3'd1: exp = TS;
        3'd2: begin exp = up[31:0]; m_hi = up[63:32]; end
        3'd3: exp = m_hi;
        3'd4: exp = m_s0;
        3'd5: exp = m_s1;
        3'd6: exp = {16'(TD), 8'd0, 8'(NC)};
        default: exp = {31'd0, m_frz};
      endcase
      m_last = exp;
    end
    frz_old = m_frz;
    if (wr) begin
      case (a)
        3'd4: m_s0 = d;
        3'd5: m_s1 = d;
        3'd7: m_frz = d[0];
        default: ;
      endcase
    end
    if (wr && a == 3'd7 && d[1]) m_cnt = 0;
    else if (!frz_old) m_cnt++;
    @(posedge clock);
    #1;
    check("rdv", {63'd0, readdatavalid}, {63'd0, rd});
    if (rd) t = $sformatf("rdata@%0d", a);
    else t = "hold";
    if (use_model) check(t, {32'd0, readdata}, {32'd0, exp});
    @(negedge clock);
    read = 1'b0; write = 1'b0;
  endtask

  logic [31:0] lo, hi;
  logic [2:0]  ra;
  logic [31:0] rd_v;
  int          r;

  initial begin
    reset = 1'b1; read = 1'b0; write = 1'b0;
    address = '0; writedata = '0;
    read1 = 1'b0; write1 = 1'b0;
    address1 = '0; writedata1 = '0;
    use_model = 1'b1;
    model_reset();
    repeat (2) @(negedge clock);
    check("rst_rdv", {63'd0, readdatavalid}, 64'd0);
    check("rst_rdata", {32'd0, readdata}, 64'd0);
    check("rst_rdv1", {63'd0, readdatavalid1}, 64'd0);
    reset = 1'b0;

    repeat (30) cyc(0, 0, 3'd0, 32'd0);
    cyc(1, 0, 3'd2, 32'd0);
    check("up_td3_30clk", {32'd0, readdata}, 64'd10);
    repeat (69) cyc(0, 0, 3'd0, 32'd0);
    read1 = 1'b1; address1 = 3'd2;
    cyc(0, 0, 3'd0, 32'd0);
    read1 = 1'b0;
    check("rdv1", {63'd0, readdatavalid1}, 64'd1);
    check("up_td1_100clk", {32'd0, readdata1}, 64'd100);
    cyc(0, 0, 3'd0, 32'd0);
    check("rdv1_pulse", {63'd0, readdatavalid1}, 64'd0);

    cyc(1, 0, 3'd0, 32'd0);
    check("sys_id", {32'd0, readdata}, {32'd0, SID});
    cyc(1, 0, 3'd1, 32'd0);
    check("timestamp", {32'd0, readdata}, {32'd0, TS});
    cyc(1, 0, 3'd6, 32'd0);
    check("config", {32'd0, readdata}, 64'h0003_0004);
    cyc(0, 0, 3'd0, 32'd0);

    cyc(0, 1, 3'd4, 32'hDEAD_BEEF);
    cyc(0, 1, 3'd5, 32'h1234_5678);
    cyc(1, 0, 3'd4, 32'd0);
    check("scratch0", {32'd0, readdata}, 64'hDEAD_BEEF);
    cyc(1, 0, 3'd5, 32'd0);
    check("scratch1", {32'd0, readdata}, 64'h1234_5678);
    cyc(0, 1, 3'd0, 32'hFFFF_FFFF);
    cyc(1, 0, 3'd0, 32'd0);
    check("ro_write", {32'd0, readdata}, {32'd0, SID});

    cyc(0, 1, 3'd7, 32'd1);
    repeat (50) cyc(0, 0, 3'd0, 32'd0);
    cyc(1, 0, 3'd2, 32'd0);
    cyc(1, 0, 3'd2, 32'd0);
    cyc(0, 1, 3'd7, 32'd2);
    cyc(1, 0, 3'd2, 32'd0);
    check("clr_le2", {63'd0, readdata <= 32'd2}, 64'd1);
    cyc(1, 0, 3'd7, 32'd0);
    check("ctrl_rd0", {32'd0, readdata}, 64'd0);

    repeat (400) begin
      r  = $urandom_range(0, 3);
      ra = 3'($urandom_range(0, 7));
      rd_v = $urandom;
      if (ra == 3'd7) rd_v = rd_v & 32'h3;
      if (r == 0) cyc(1, 0, ra, 32'd0);
      else if (r == 1) cyc(0, 1, ra, rd_v);
      else cyc(0, 0, 3'd0, 32'd0);
    end

    cyc(0, 1, 3'd7, 32'd0);
    use_model = 1'b0;
    dut.uptime <= 64'h0000_0000_FFFF_FFFF;
    dut.presc  <= 16'(TD - 1);
    cyc(1, 0, 3'd2, 32'd0);
    lo = readdata;
    cyc(1, 0, 3'd3, 32'd0);
    hi = readdata;
    check("carry_pair",
          {63'd0, ({hi, lo} == 64'h0000_0000_FFFF_FFFF) ||
                  ({hi, lo} == 64'h0000_0001_0000_0000)},
          64'd1);
    cyc(1, 0, 3'd2, 32'd0);
    check("carry_after", {32'd0, readdata}, 64'd0);
    cyc(1, 0, 3'd3, 32'd0);
    check("carry_hi", {32'd0, readdata}, 64'd1);

    cyc(0, 1, 3'd4, 32'hA5A5_0001);
    read = 1'b1; address = 3'd4;
    @(posedge clock);
    #1;
    reset = 1'b1; read = 1'b0;
    #1;
    check("rst_mid_rdv", {63'd0, readdatavalid}, 64'd0);
    check("rst_mid_rdata", {32'd0, readdata}, 64'd0);
    @(posedge clock);
    @(negedge clock);
    check("rst_hold_rdv", {63'd0, readdatavalid}, 64'd0);
    reset = 1'b0;
    model_reset();
    use_model = 1'b1;
    cyc(1, 0, 3'd4, 32'd0);
    check("rst_scratch0", {32'd0, readdata}, 64'd0);
    cyc(1, 0, 3'd2, 32'd0);
    check("rst_uptime", {32'd0, readdata}, 64'd0);
    repeat (6) cyc(0, 0, 3'd0, 32'd0);
    cyc(1, 0, 3'd2, 32'd0);
    cyc(1, 0, 3'd3, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sysid_uptime.md
# sysid_uptime

Parametrised system-identification slave for the multi-processor SoC: an Avalon-MM register block that returns the system ID, build timestamp and a static configuration word. It also provides a free-running 64-bit uptime counter with tear-free reads, two scratch registers and a counter control register. It sits on each processor's data bus alongside the FIFO and peripheral slaves. Reads have a fixed one-cycle latency with `readdatavalid`.

## Interface
- `SYS_ID`, 32'h0000_0000, value returned at word 0
- `TIMESTAMP`, 32'h0000_0000, build time (Unix seconds) returned at word 1
- `NUM_CPUS`, 2, processor count reported in CONFIG[7:0]; legal range 1–255
- `TICK_DIV`, 1, clocks per uptime increment; legal range 1–65535
- `clock`  in  1  sole clock; all state on its rising edge
- `reset`  in  1  asynchronous, active-high reset
- `address`  in  3  word address
- `read`  in  1  read strobe, one cycle per transfer
- `write`  in  1  write strobe, one cycle per transfer
- `writedata`  in  32  write data
- `readdata`  out  32  read data, valid when `readdatavalid`=1
- `readdatavalid`  out  1  one-cycle pulse, one cycle after an accepted `read`

## Operation
- Register map (word address):
  - 0 ID (RO) = `SYS_ID`
  - 1 TS (RO) = `TIMESTAMP`
  - 2 UP_LO (RO) = uptime[31:0]; the read also copies uptime[63:32] into the `hi_shadow` register
  - 3 UP_HI (RO) = `hi_shadow`
  - 4 SCRATCH0 (RW)
  - 5 SCRATCH1 (RW)
  - 6 CONFIG (RO) = {16'd`TICK_DIV`, 8'd0, 8'd`NUM_CPUS`}
  - 7 CTRL: bit0 FREEZE (RW); bit1 CLEAR (write-1 pulse, reads 0); bits 31:2 read 0
- Writes to read-only addresses are ignored.
- Uptime:
  - The prescaler counts 0..`TICK_DIV`−1.
  - On its terminal count, uptime increments by 1 and the prescaler returns to 0.
  - When `TICK_DIV`=1, uptime increments every clock.
  - The counter is 64 bits and wraps from all-ones to 0 with no flag.
- FREEZE=1 holds both the prescaler and uptime. Clearing FREEZE resumes from the held values.
- A CLEAR write zeroes uptime and the prescaler on the next edge. It works regardless of FREEZE. FREEZE is written in the same transfer from writedata[0].
- Tear-free 64-bit read protocol: software reads UP_LO, then UP_HI. `hi_shadow` is updated only by UP_LO reads.
- `read` and `write` asserted in the same cycle is illegal; the behaviour is unspecified and is not checked.
- No wait states: every `read`/`write` is accepted in the cycle it is asserted.

## Timing
- Reset values:
  - `readdata`=0, `readdatavalid`=0
  - uptime=0, prescaler=0, `hi_shadow`=0
  - SCRATCH0/1=0, FREEZE=0
- Read latency: `read` sampled at edge N; `readdata` and `readdatavalid`=1 are presented after edge N, for one cycle.
- Back-to-back reads: one result per cycle, in order.
- `readdata` holds its last value when `readdatavalid`=0.
- Value captured by an UP_LO read: the uptime register value before edge N. `hi_shadow` receives the upper half of that same value, so a carry at edge N is never split between the two words.
- Write effect: a write at edge N is visible to a read sampled at edge N+1.
- Simultaneous CLEAR and tick at the same edge: CLEAR wins, uptime=0.
- Simultaneous UP_LO read and CLEAR at the same edge is not possible (one transfer per cycle).
- Reset mid-transfer: a pending `readdatavalid` is dropped and all state returns to reset values asynchronously. The first transfer after reset deassertion completes normally.

## Test plan
- Reset, then read addresses 0, 1 and 6 with `SYS_ID`=32'h63BB_00C3, `TIMESTAMP`=32'h5F00_0000, `NUM_CPUS`=4, `TICK_DIV`=3 -> 32'h63BB_00C3, 32'h5F00_0000 and 32'h0003_0004, each exactly 1 cycle after `read` with a single `readdatavalid` pulse.
- `TICK_DIV`=1: hold 100 clocks after reset, then read UP_LO -> readdata=100 ±0 per the capture rule. With `TICK_DIV`=3, 30 clocks -> readdata=10.
- Carry test:
  - Force uptime to 32'hFFFF_FFFF via a bench hierarchical deposit.
  - Read UP_LO on the edge where uptime carries, then read UP_HI.
  - Required: the pair is either {0, FFFF_FFFF} or {1, 0}, never a torn combination.
- Write 32'hDEAD_BEEF to SCRATCH0 and 32'h1234_5678 to SCRATCH1, then read both back -> written values. Write to address 0, then read it -> still `SYS_ID`.
- Write CTRL=1 (freeze) and wait 50 clocks: two UP_LO reads are equal. Write CTRL=2 (clear and unfreeze): the next UP_LO read is ≤2 and CTRL reads 0.
- Assert `reset` for 1 cycle between a `read` and its `readdatavalid` -> no `readdatavalid` pulse, SCRATCH0 reads 0 and uptime restarts from 0.
